// File: rtl/binary_erode_3x3_pkg.sv
// Shared definitions for the 3x3 binary morphology stage: foreground rule,
// operating-mode encodings, counter sizing and the 9-bit window reduction.
package binary_erode_3x3_pkg;

  localparam int MODE_ERODE  = 0;
  localparam int MODE_DILATE = 1;

  // A pixel is foreground when its most significant bit equals this value.
  localparam logic FG_VALUE = 1'b1;

  // Binarise a pixel from its MSB.
  function automatic logic is_fg(input logic msb);
    return (msb == FG_VALUE);
  endfunction

  // Counter width for a range of n values; never less than 1 bit.
  function automatic int clog2(input int n);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < n) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Erosion is the AND of the window, dilation the OR.
  function automatic logic morph_reduce(input logic [8:0] win, input int mode);
    logic res;
    case (mode)
      MODE_ERODE:  res = &win;
      MODE_DILATE: res = |win;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/binary_erode_3x3_if.sv
// Pixel stream bundle: three vertically aligned input taps plus the
// eroded/dilated output stream with line and frame markers.
interface binary_erode_3x3_if #(
  parameter int DW = 24
);
  logic          i_de;
  logic [DW-1:0] din_top;
  logic [DW-1:0] din_mid;
  logic [DW-1:0] din_bot;
  logic          o_de;
  logic [DW-1:0] dout;
  logic          o_eol;
  logic          o_eof;

  // Source of the taps / consumer of the result.
  modport master (
    output i_de, din_top, din_mid, din_bot,
    input  o_de, dout, o_eol, o_eof
  );

  // The morphology stage itself.
  modport slave (
    input  i_de, din_top, din_mid, din_bot,
    output o_de, dout, o_eol, o_eof
  );
endinterface

// File: rtl/binary_erode_3x3_window_col_shift3.sv
// Three-column by three-row bit window. Columns shift oldest-to-newest only
// when enabled. The look-ahead output is the window as it will be after this
// cycle, so the downstream result register sees the incoming column at once.
module window_col_shift3
  import binary_erode_3x3_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic [2:0] i_col,     // {top, mid, bot} of the newest column
  output logic [8:0] o_win_nxt  // {c0, c1, c2} after this cycle's shift
);

  logic [2:0] r_c0;
  logic [2:0] r_c1;
  logic [2:0] r_c2;
  logic [2:0] w_c0_nxt;
  logic [2:0] w_c1_nxt;
  logic [2:0] w_c2_nxt;

  // Next window contents: shift on enable, otherwise hold.
  always_comb begin
    w_c0_nxt = r_c0;
    w_c1_nxt = r_c1;
    w_c2_nxt = r_c2;
    if (i_en) begin
      w_c0_nxt = r_c1;
      w_c1_nxt = r_c2;
      w_c2_nxt = i_col;
    end else begin
      w_c0_nxt = r_c0;
      w_c1_nxt = r_c1;
      w_c2_nxt = r_c2;
    end
  end

  assign o_win_nxt = {w_c0_nxt, w_c1_nxt, w_c2_nxt};

  // Window column registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c0 <= 3'b000;
      r_c1 <= 3'b000;
      r_c2 <= 3'b000;
    end else begin
      r_c0 <= w_c0_nxt;
      r_c1 <= w_c1_nxt;
      r_c2 <= w_c2_nxt;
    end
  end

endmodule

// File: rtl/binary_erode_3x3.sv
// 3x3 binary erosion/dilation stage fed by one-line delay taps. Emits W
// output beats per row: W-1 driven by input beats at columns 1..W-1 and a
// final flush beat for the right border column carrying the line/frame marks.
module binary_erode_3x3
  import binary_erode_3x3_pkg::*;
#(
  parameter int IMG_WIDTH_DATA = 24,
  parameter int IMG_WIDTH_LINE = 800,
  parameter int IMG_HEIGHT     = 600,
  parameter int MODE           = MODE_ERODE
) (
  input logic               clk,
  input logic               reset_n,
  binary_erode_3x3_if.slave bus
);

  localparam int XW = clog2(IMG_WIDTH_LINE);
  localparam int RW = clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_ZERO = XW'(0);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH_LINE - 1);
  localparam logic [RW-1:0] R_ZERO = RW'(0);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 3);

  logic [XW-1:0]             r_x;
  logic [RW-1:0]             r_r;
  logic                      r_flush;
  logic                      r_flush_eof;
  logic                      r_o_de;
  logic                      r_o_eol;
  logic                      r_o_eof;
  logic [IMG_WIDTH_DATA-1:0] r_dout;

  logic       w_beat;
  logic       w_last;
  logic [2:0] w_col;
  logic [8:0] w_win;
  logic       w_pix;

  assign w_beat = bus.i_de;
  assign w_last = bus.i_de && (r_x == X_LAST);
  assign w_col  = {is_fg(bus.din_top[IMG_WIDTH_DATA-1]),
                   is_fg(bus.din_mid[IMG_WIDTH_DATA-1]),
                   is_fg(bus.din_bot[IMG_WIDTH_DATA-1])};

  window_col_shift3 u_window (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (w_beat),
    .i_col     (w_col),
    .o_win_nxt (w_win)
  );

  // Result bit for the centre column x-1; centre column 0 is forced to background.
  always_comb begin
    w_pix = 1'b0;
    if (r_x == X_ONE) begin
      w_pix = 1'b0;
    end else begin
      w_pix = morph_reduce(w_win, MODE);
    end
  end

  // Column/row counters and the one-cycle flush flag following a line's last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x         <= X_ZERO;
      r_r         <= R_ZERO;
      r_flush     <= 1'b0;
      r_flush_eof <= 1'b0;
    end else begin
      r_flush     <= w_last;
      r_flush_eof <= w_last && (r_r == R_LAST);
      if (w_beat) begin
        if (r_x == X_LAST) begin
          r_x <= X_ZERO;
          r_r <= (r_r == R_LAST) ? R_ZERO : (r_r + RW'(1));
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  // Output register: the flush beat (right border) takes the slot of the next
  // line's column-0 beat, which never produces output, so they cannot collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_o_de  <= 1'b0;
      r_o_eol <= 1'b0;
      r_o_eof <= 1'b0;
      r_dout  <= {IMG_WIDTH_DATA{1'b0}};
    end else if (r_flush) begin
      r_o_de  <= 1'b1;
      r_o_eol <= 1'b1;
      r_o_eof <= r_flush_eof;
      r_dout  <= {IMG_WIDTH_DATA{1'b0}};
    end else if (w_beat && (r_x != X_ZERO)) begin
      r_o_de  <= 1'b1;
      r_o_eol <= 1'b0;
      r_o_eof <= 1'b0;
      r_dout  <= {IMG_WIDTH_DATA{w_pix}};
    end else begin
      r_o_de  <= 1'b0;
      r_o_eol <= 1'b0;
      r_o_eof <= 1'b0;
      r_dout  <= {IMG_WIDTH_DATA{1'b0}};
    end
  end

  assign bus.o_de  = r_o_de;
  assign bus.o_eol = r_o_eol;
  assign bus.o_eof = r_o_eof;
  assign bus.dout  = r_dout;

endmodule

// File: tb/tb_binary_erode_3x3.sv
// Bench for binary_erode_3x3: an erosion and a dilation instance see the same
// taps; a column-indexed line model predicts every output cycle for both.
module tb_binary_erode_3x3;

  localparam int DW = 24;
  localparam int W  = 8;
  localparam int H  = 5;
  localparam logic [31:0] ONES = 32'h00FF_FFFF;

  logic clk;
  logic reset_n;

  binary_erode_3x3_if #(.DW(DW)) bus_e ();
  binary_erode_3x3_if #(.DW(DW)) bus_d ();

  binary_erode_3x3 #(
    .IMG_WIDTH_DATA (DW), .IMG_WIDTH_LINE (W), .IMG_HEIGHT (H), .MODE (0)
  ) u_dut_e (
    .clk (clk), .reset_n (reset_n), .bus (bus_e)
  );

  binary_erode_3x3 #(
    .IMG_WIDTH_DATA (DW), .IMG_WIDTH_LINE (W), .IMG_HEIGHT (H), .MODE (1)
  ) u_dut_d (
    .clk (clk), .reset_n (reset_n), .bus (bus_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pixels of the current line indexed by column.
  bit lt [W];
  bit lm [W];
  bit lb [W];
  int m_x, m_r;
  bit m_flush, m_flush_eof;
  logic        exp_de, exp_eol, exp_eof;
  logic [31:0] exp_e, exp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_r = 0; m_flush = 0; m_flush_eof = 0;
  endtask

  task automatic model_step(input bit de, input bit bt, input bit bm, input bit bb);
    int c;
    int ones;
    exp_de = 1'b0; exp_eol = 1'b0; exp_eof = 1'b0; exp_e = 32'd0; exp_d = 32'd0;
    if (m_flush) begin
      exp_de = 1'b1; exp_eol = 1'b1; exp_eof = m_flush_eof;
    end
    m_flush = 0;
    if (de) begin
      lt[m_x] = bt; lm[m_x] = bm; lb[m_x] = bb;
      if (m_x >= 1) begin
        c = m_x - 1;
        exp_de = 1'b1;
        if (c != 0) begin
          ones = 0;
          for (int k = c - 1; k <= c + 1; k++) begin
            ones += int'(lt[k]) + int'(lm[k]) + int'(lb[k]);
          end
          exp_e = (ones == 9) ? ONES : 32'd0;
          exp_d = (ones > 0)  ? ONES : 32'd0;
        end
      end
      if (m_x == W - 1) begin
        m_flush = 1;
        m_flush_eof = (m_r == H - 3);
        m_r = (m_r + 1) % (H - 2);
        m_x = 0;
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("de_e",   32'(bus_e.o_de),  32'(exp_de));
    chk("eol_e",  32'(bus_e.o_eol), 32'(exp_eol));
    chk("eof_e",  32'(bus_e.o_eof), 32'(exp_eof));
    chk("dout_e", 32'(bus_e.dout),  exp_e);
    chk("de_d",   32'(bus_d.o_de),  32'(exp_de));
    chk("eol_d",  32'(bus_d.o_eol), 32'(exp_eol));
    chk("eof_d",  32'(bus_d.o_eof), 32'(exp_eof));
    chk("dout_d", 32'(bus_d.dout),  exp_d);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_de_e"},   32'(bus_e.o_de),  32'd0);
    chk({tag, "_eol_e"},  32'(bus_e.o_eol), 32'd0);
    chk({tag, "_eof_e"},  32'(bus_e.o_eof), 32'd0);
    chk({tag, "_dout_e"}, 32'(bus_e.dout),  32'd0);
    chk({tag, "_de_d"},   32'(bus_d.o_de),  32'd0);
    chk({tag, "_dout_d"}, 32'(bus_d.dout),  32'd0);
  endtask

  // Drive one cycle of taps (MSB carries the bit, low bits are noise), then check.
  task automatic step(input bit de, input bit bt, input bit bm, input bit bb);
    logic [DW-1:0] pt, pm, pb;
    pt = {bt, 23'($urandom)};
    pm = {bm, 23'($urandom)};
    pb = {bb, 23'($urandom)};
    bus_e.i_de = de; bus_e.din_top = pt; bus_e.din_mid = pm; bus_e.din_bot = pb;
    bus_d.i_de = de; bus_d.din_top = pt; bus_d.din_mid = pm; bus_d.din_bot = pb;
    @(posedge clk);
    #1;
    model_step(de, bt, bm, bb);
    check_outputs();
  endtask

  initial begin
    reset_n = 1'b0;
    bus_e.i_de = 1'b0; bus_e.din_top = '0; bus_e.din_mid = '0; bus_e.din_bot = '0;
    bus_d.i_de = 1'b0; bus_d.din_top = '0; bus_d.din_mid = '0; bus_d.din_bot = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    reset_n = 1'b1;

    // All foreground, continuous beats: one full frame plus a row of the next.
    for (int l = 0; l < 4; l++) begin
      for (int x = 0; x < W; x++) step(1'b1, 1'b1, 1'b1, 1'b1);
    end
    // Single background pixel on the centre row at column 4.
    for (int x = 0; x < W; x++) step(1'b1, 1'b1, (x != 4), 1'b1);
    // Beats every other cycle through a line; flush lands two cycles after column 7.
    for (int x = 0; x < W; x++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // Dilation pattern: only the top tap at column 2 is foreground.
    for (int x = 0; x < W; x++) step(1'b1, (x == 2), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random gaps and mostly-foreground pixels across several frames.
    for (int n = 0; n < 240; n++) begin
      step(($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 85));
    end
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-row reset: five beats in, then pulse reset for one clock.
    model_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int x = 0; x < 5; x++) step(1'b1, 1'b1, 1'b1, 1'b1);
    bus_e.i_de = 1'b0;
    bus_d.i_de = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < W; x++) step(1'b1, 1'b1, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/binary_erode_3x3.md
Name: binary_erode_3x3

Overview:
- Neighbourhood stage directly downstream of the one-line delay buffers in the binary image etch pipeline.
- Takes three vertically aligned taps of a binary stream, builds a 3x3 window with column shift registers, and emits the eroded pixel (or dilated, by MODE).
- The taps are: the current row, the row delayed one line, and the row delayed two lines.
- Output is a pixel stream with line/frame markers for the next stage (writer or second morphology pass).

Parameters:
- IMG_WIDTH_DATA, 24, pixel width; foreground iff pixel MSB = 1.
- IMG_WIDTH_LINE, 800, pixels per line (W), >= 3.
- IMG_HEIGHT, 600, input lines per frame (H); output rows per frame = H-2.
- MODE, 0, 0 = erosion (AND of 9 pixels), 1 = dilation (OR of 9 pixels).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- i_de  in  1  all three taps valid this cycle.
- din_top  in  IMG_WIDTH_DATA  tap delayed two lines (row y-2).
- din_mid  in  IMG_WIDTH_DATA  tap delayed one line (row y-1, window centre row).
- din_bot  in  IMG_WIDTH_DATA  current row y.
- o_de  out  1  output pixel valid.
- dout  out  IMG_WIDTH_DATA  result: all ones (foreground) or all zeros.
- o_eol  out  1  high with o_de on the last output pixel of a row.
- o_eof  out  1  high with o_de on the last output pixel of the frame.

Behaviour:
- Reset: all outputs 0; window registers 0; column counter x=0; row counter r=0; flush_pending=0. Asserting reset mid-frame discards the partial window and restarts at column 0 / row 0.
- Binarise: each tap bit = tap[IMG_WIDTH_DATA-1].
- Window:
  - Three columns c0 (oldest), c1 (centre), c2 (newest), 3 bits each.
  - Shift only on i_de: c0<=c1, c1<=c2, c2<={top,mid,bot}.
  - No shift without i_de; gaps mid-line are legal.
- Column counter x (0..W-1): increments on each i_de beat and wraps to 0 after W-1. On that wrap beat, r increments, wrapping at H-3 -> 0.
- Output timing (registered, 1 cycle):
  - An i_de beat at column x>=1 produces o_de=1 on the next cycle, for centre column x-1.
  - A beat at x=0 produces no output.
  - A beat at x=W-1 also sets flush_pending. On the cycle after the centre W-2 output, o_de=1 again for centre column W-1, then flush_pending clears.
  - This flush beat is independent of i_de. It occupies the slot left empty by the next line's x=0 beat, so output beats never collide.
  - Exactly W output beats per row.
- Result:
  - Centre column 0 or W-1: dout = 0 (border forced background, both MODEs).
  - Otherwise MODE 0: dout = all ones iff all 9 window bits = 1; MODE 1: all ones iff any bit = 1.
- Markers: o_eol=1 on the flush beat (centre W-1). o_eof = o_eol when r (for that row) = H-3. After the o_eof beat, r wraps to 0.
- Rows: top and bottom image rows are never centred; output frame is W x (H-2).
- Latency: an input beat at column x+1 yields centre column x one cycle later; the last pixel of a row appears 2 cycles after the W-1 input beat.

Decomposition:
- Shared package: the MSB-foreground rule, MODE encodings (MODE_ERODE=0, MODE_DILATE=1), and the counter width function clog2(IMG_WIDTH_LINE).
- One natural sub-module: window_col_shift3 (3x3 bit shift register with enable and async reset). Counters, flush logic and reduction stay in the top.

Test Plan:
- Use W=8, H=5, MODE=0. All taps 24'hFFFFFF, i_de continuous -> per row dout pattern 0,FF..,FF..(x6),0. o_eol on beat 8. o_eof on the third row's beat 8, then rows repeat.
- Single zero pixel on din_mid at column 4, all else foreground -> centre columns 3,4,5 output 0; others as above.
- i_de toggling 1/0 every cycle through a line -> same 8 outputs per row as continuous, each 1 cycle after its beat. Flush beat 2 cycles after the column-7 beat.
- Back-to-back lines with no i_de gap -> output o_de continuous with no dropped or duplicated beat; next-line x=0 yields no output.
- MODE=1, all taps 0 except din_top MSB=1 at column 2 -> centre columns 1,2,3 output 24'hFFFFFF; columns 0 and 7 stay 0.
- reset_n low for 1 cycle mid-row at x=5 -> o_de/o_eol/o_eof go 0 immediately. After release, the next beat is treated as column 0, row 0 and produces no output.
